// File: rtl/edc_gen_corrector.sv
// edc_gen_corrector
// SECDED generator/corrector for the 32-bit memory data path.
//   Write: produces the 8-bit check byte stored beside the data word.
//   Read:  recomputes the check bits, forms the syndrome, corrects a
//          single-bit data error and flags uncorrectable errors.
// All outputs are registered (1-cycle latency, full throughput).
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst               asynchronous active-high reset, clears every output
//   i_valid             qualifies the inputs this cycle
//   i_write_enabled     1 = write (generate ECC), 0 = read (check/correct)
//   i_data[31:0]        data word (from mux on write, memory on read)
//   i_ecc[7:0]          stored check byte (ignored on write; bit 7 always ignored)
//   o_valid             i_valid delayed by one cycle
//   o_ecc_syndrome[7:0] write: check byte; read: {0, p, s}
//   o_data[31:0]        write: i_data; read: corrected data
//   o_error_detected    read only: any error found
//   o_uncorrected_error read only: error present but not correctable
module edc_gen_corrector (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_write_enabled,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_ecc,
    output logic        o_valid,
    output logic [7:0]  o_ecc_syndrome,
    output logic [31:0] o_data,
    output logic        o_error_detected,
    output logic        o_uncorrected_error
);

    localparam int DATA_W = 32;
    localparam int CHK_W  = 6;

    // Hamming position of data bit idx: the idx-th value of 3..38 that is
    // not a power of two (1 and 2 are below the range already).
    function automatic logic [5:0] hpos(input int idx);
        int          n;
        logic [5:0]  r;
        logic [31:0] pv;
        n = 0;
        r = '0;
        for (int p = 3; p <= 38; p++) begin
            if (p != 4 && p != 8 && p != 16 && p != 32) begin
                pv = p;
                if (n == idx) r = pv[5:0];
                n++;
            end
        end
        return r;
    endfunction

    // c[k] = XOR of data bits whose Hamming position has bit k set.
    function automatic logic [CHK_W-1:0] gen_check(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        logic [5:0]       pos;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pos = hpos(i);
            for (int k = 0; k < CHK_W; k++) begin
                if (pos[k]) c[k] = c[k] ^ d[i];
            end
        end
        return c;
    endfunction

    // One-hot mask of the data bit addressed by syndrome s (zero if s is not
    // a data position, i.e. a check-bit position or out of range).
    function automatic logic [DATA_W-1:0] flip_mask(input logic [5:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (hpos(i) == s) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Reserved stored bit carries no information.
    logic unused_ecc_msb;
    assign unused_ecc_msb = i_ecc[7];

    logic [CHK_W-1:0]  chk_p0;
    logic              par_p0;
    logic [CHK_W-1:0]  syn_s_p0;
    logic              syn_p_p0;
    logic [7:0]        ecc_syn_p0;
    logic [DATA_W-1:0] data_p0;
    logic              det_p0;
    logic              unc_p0;

    // Stage p0: combinational generate / syndrome / correct
    always_comb begin
        chk_p0     = gen_check(i_data);
        par_p0     = (^i_data) ^ (^chk_p0);
        syn_s_p0   = chk_p0 ^ i_ecc[5:0];
        // Parity of all received bits: recomputed overall parity vs stored,
        // folded with the check-bit differences.
        syn_p_p0   = (par_p0 ^ i_ecc[6]) ^ (^syn_s_p0);
        ecc_syn_p0 = '0;
        data_p0    = i_data;
        det_p0     = 1'b0;
        unc_p0     = 1'b0;
        if (i_write_enabled) begin
            ecc_syn_p0 = {1'b0, par_p0, chk_p0};
        end else begin
            ecc_syn_p0 = {1'b0, syn_p_p0, syn_s_p0};
            det_p0     = syn_p_p0 || (syn_s_p0 != '0);
            if (syn_p_p0) begin
                // Odd parity: single error; syndrome above 38 cannot be one.
                unc_p0  = (syn_s_p0 > 6'd38);
                data_p0 = i_data ^ flip_mask(syn_s_p0);
            end else begin
                unc_p0  = (syn_s_p0 != '0);
            end
        end
    end

    // Stage p1: output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid             <= 1'b0;
            o_ecc_syndrome      <= '0;
            o_data              <= '0;
            o_error_detected    <= 1'b0;
            o_uncorrected_error <= 1'b0;
        end else begin
            o_valid             <= i_valid;
            o_ecc_syndrome      <= ecc_syn_p0;
            o_data              <= data_p0;
            o_error_detected    <= det_p0;
            o_uncorrected_error <= unc_p0;
        end
    end

endmodule

// File: tb/tb_edc_gen_corrector.sv
module tb_edc_gen_corrector;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        we;
    logic [31:0] data;
    logic [7:0]  ecc;
    logic        o_valid;
    logic [7:0]  o_ecc_syndrome;
    logic [31:0] o_data;
    logic        o_error_detected;
    logic        o_uncorrected_error;

    int n_tests = 0;
    int n_fail  = 0;

    edc_gen_corrector dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_valid             (valid),
        .i_write_enabled     (we),
        .i_data              (data),
        .i_ecc               (ecc),
        .o_valid             (o_valid),
        .o_ecc_syndrome      (o_ecc_syndrome),
        .o_data              (o_data),
        .o_error_detected    (o_error_detected),
        .o_uncorrected_error (o_uncorrected_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] data;
        logic [7:0]  ecc;
        logic [7:0]  exp_syn;
        logic [31:0] exp_data;
        logic        exp_det;
        logic        exp_unc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic v, input logic [7:0] syn,
                             input logic [31:0] d, input logic det, input logic unc);
        check({name, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        check({name, ".syn"},   {24'd0, o_ecc_syndrome}, {24'd0, syn});
        check({name, ".data"},  o_data, d);
        check({name, ".det"},   {31'd0, o_error_detected}, {31'd0, det});
        check({name, ".unc"},   {31'd0, o_uncorrected_error}, {31'd0, unc});
    endtask

    // Drive one word, wait for the capturing edge, then sample 1 time unit later.
    task automatic apply(input logic v, input logic w, input logic [31:0] d, input logic [7:0] e);
        valid = v;
        we    = w;
        data  = d;
        ecc   = e;
        @(posedge clk);
        #1;
    endtask

    // Hamming positions written out by hand: 3,5,6,7,9..15,17..31,33..38.
    logic [5:0] pos_tab[32];

    initial begin
        int k;
        k = 0;
        pos_tab[k++] = 6'd3; pos_tab[k++] = 6'd5; pos_tab[k++] = 6'd6; pos_tab[k++] = 6'd7;
        for (int p = 9;  p <= 15; p++) pos_tab[k++] = 6'(p);
        for (int p = 17; p <= 31; p++) pos_tab[k++] = 6'(p);
        for (int p = 33; p <= 38; p++) pos_tab[k++] = 6'(p);

        vecs.push_back('{"wr_zero",   1'b1, 32'h00000000, 8'h00, 8'h00, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"wr_one",    1'b1, 32'h00000001, 8'hFF, 8'h43, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"wr_ones",   1'b1, 32'hFFFFFFFF, 8'h00, 8'h18, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"wr_msb",    1'b1, 32'h80000000, 8'h00, 8'h26, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"rd_clean",  1'b0, 32'h00000001, 8'h43, 8'h00, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"rd_d0err",  1'b0, 32'h00000001, 8'h00, 8'h43, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"rd_c0err",  1'b0, 32'h00000000, 8'h01, 8'h41, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"rd_perr",   1'b0, 32'h00000000, 8'h40, 8'h40, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"rd_double", 1'b0, 32'h00000003, 8'h00, 8'h06, 32'h00000003, 1'b1, 1'b1});
        vecs.push_back('{"rd_rsvd",   1'b0, 32'h00000000, 8'h80, 8'h00, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"rd_ones",   1'b0, 32'hFFFFFFFF, 8'h18, 8'h00, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"rd_multi",  1'b0, 32'h00000000, 8'h67, 8'h67, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"rd_d31err", 1'b0, 32'h80000000, 8'h00, 8'h66, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"wr_after",  1'b1, 32'h00000001, 8'h00, 8'h43, 32'h00000001, 1'b0, 1'b0});

        rst   = 1'b1;
        valid = 1'b1;
        we    = 1'b1;
        data  = 32'hDEADBEEF;
        ecc   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // Back-to-back table, reads and writes interleaved
        foreach (vecs[i]) begin
            apply(1'b1, vecs[i].we, vecs[i].data, vecs[i].ecc);
            check_all(vecs[i].name, 1'b1, vecs[i].exp_syn, vecs[i].exp_data,
                      vecs[i].exp_det, vecs[i].exp_unc);
        end

        // Every single-bit flip of 0xFFFFFFFF under its clean check byte
        for (int b = 0; b < 32; b++) begin
            apply(1'b1, 1'b0, 32'hFFFFFFFF ^ (32'h1 << b), 8'h18);
            check_all($sformatf("sweep%0d", b), 1'b1, {2'b01, pos_tab[b]},
                      32'hFFFFFFFF, 1'b1, 1'b0);
        end

        // Registers load even with i_valid low
        apply(1'b0, 1'b1, 32'h00000001, 8'h00);
        check_all("novalid", 1'b0, 8'h43, 32'h00000001, 1'b0, 1'b0);

        // Mid-stream asynchronous reset clears outputs immediately
        apply(1'b1, 1'b0, 32'h00000003, 8'h00);
        check_all("pre_rst", 1'b1, 8'h06, 32'h00000003, 1'b1, 1'b1);
        valid = 1'b1;
        we    = 1'b0;
        data  = 32'h00000003;
        ecc   = 8'h00;
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_hold", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        apply(1'b1, 1'b1, 32'h00000001, 8'h00);
        check_all("post_rst", 1'b1, 8'h43, 32'h00000001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
